// File: rtl/lcd_responder_if.sv
// lcd_responder_if: 4-bit character-LCD bus between lcd_ctrl (master) and the
// lcd_responder device model (slave), including the optional read-back nibble.
interface lcd_responder_if;
   logic [11:8] SF_D;
   logic        LCD_E;
   logic        LCD_RS;
   logic        LCD_RW;
   logic [3:0]  sf_d_out;
   logic        sf_d_oe;

   modport master (
      output SF_D, LCD_E, LCD_RS, LCD_RW,
      input  sf_d_out, sf_d_oe
   );

   modport slave (
      input  SF_D, LCD_E, LCD_RS, LCD_RW,
      output sf_d_out, sf_d_oe
   );
endinterface

// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-style device end of the 4-bit LCD bus with 80-byte DDRAM.
// Define LCD_RESP_READ_EN to compile in read-cycle (RW=1) support.
module lcd_responder #(
   parameter int unsigned BUSY_CYCLES  = 2000,
   parameter int unsigned CLEAR_CYCLES = 82000
) (
   input  logic           clk,
   input  logic           reset,
   lcd_responder_if.slave bus,
   input  logic [6:0]     disp_addr,
   output logic [7:0]     disp_char,
   output logic           busy,
   output logic           four_bit_mode,
   output logic           display_on,
   output logic           entry_inc,
   output logic [6:0]     cursor_addr,
   output logic           cmd_valid,
   output logic [7:0]     cmd_byte,
   output logic           cmd_rs,
   output logic           protocol_err
);
   localparam int unsigned SWEEP_LEN  = 80;
   localparam int unsigned CLEAR_LOAD = (CLEAR_CYCLES > SWEEP_LEN) ? CLEAR_CYCLES : SWEEP_LEN;
   localparam int unsigned MAX_LOAD   = (BUSY_CYCLES > CLEAR_LOAD) ? BUSY_CYCLES : CLEAR_LOAD;
   localparam int          CNT_W      = $clog2(MAX_LOAD + 1);

   typedef enum logic [1:0] {ST_BOOT, ST_INIT, ST_IDLE, ST_CLEAR} state_t;

   state_t           state, state_d;
   logic [6:0]       sweep_idx, sweep_idx_d;
   logic [CNT_W-1:0] busy_cnt, busy_cnt_d;

   logic             e_p0, e_p1, e_p2;
   logic [3:0]       d_p0, d_p1;
   logic             rs_p0, rs_p1, rw_p0, rw_p1;
   logic [3:0]       lat_d;
   logic             lat_rs, lat_rw;
   logic             stb_p2;

   logic             phase, phase_d;
   logic [3:0]       hi_nib, hi_nib_d;
   logic [6:0]       ac_d;
   logic             entry_inc_d, display_on_d, four_bit_d;
   logic             cmd_valid_d, cmd_rs_d, err_d;
   logic [7:0]       cmd_byte_d;
   logic [7:0]       exec_byte;

   logic             ram_we;
   logic [6:0]       ram_widx;
   logic [7:0]       ram_wdata;
   logic [7:0]       ram [0:SWEEP_LEN-1];

   // DDRAM row 0 is 0x00-0x27, row 1 is 0x40-0x67; packed into 80 contiguous bytes.
   function automatic logic [6:0] ac_to_idx(input logic [6:0] a);
      return a[6] ? (7'd40 + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
   endfunction

   function automatic logic addr_ok(input logic [6:0] a);
      return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
   endfunction

   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
      if (inc) begin
         if (a == 7'h27)      return 7'h40;
         else if (a == 7'h67) return 7'h00;
         else                 return a + 7'd1;
      end else begin
         if (a == 7'h00)      return 7'h67;
         else if (a == 7'h40) return 7'h27;
         else                 return a - 7'd1;
      end
   endfunction

   assign busy = (busy_cnt != '0);

   // p0/p1: pin synchronizers; p2: E history for edge detect and strobe event
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_p0   <= 1'b0;
         e_p1   <= 1'b0;
         e_p2   <= 1'b0;
         stb_p2 <= 1'b0;
      end else begin
         e_p0   <= bus.LCD_E;
         e_p1   <= e_p0;
         e_p2   <= e_p1;
         stb_p2 <= e_p2 & ~e_p1;
      end
   end

   always_ff @(posedge clk) begin
      d_p0  <= bus.SF_D;
      d_p1  <= d_p0;
      rs_p0 <= bus.LCD_RS;
      rs_p1 <= rs_p0;
      rw_p0 <= bus.LCD_RW;
      rw_p1 <= rw_p0;
      if (e_p1) begin
         lat_d  <= d_p1;
         lat_rs <= rs_p1;
         lat_rw <= rw_p1;
      end
      hi_nib <= hi_nib_d;
   end

   always_ff @(posedge clk) begin
      if (ram_we) ram[ram_widx] <= ram_wdata;
   end

   // Execute stage: decode the strobe seen one cycle earlier
   always_comb begin
      state_d      = state;
      sweep_idx_d  = sweep_idx;
      busy_cnt_d   = busy ? (busy_cnt - CNT_W'(1)) : busy_cnt;
      phase_d      = phase;
      hi_nib_d     = hi_nib;
      ac_d         = cursor_addr;
      entry_inc_d  = entry_inc;
      display_on_d = display_on;
      four_bit_d   = four_bit_mode;
      cmd_valid_d  = 1'b0;
      cmd_byte_d   = cmd_byte;
      cmd_rs_d     = cmd_rs;
      err_d        = 1'b0;
      ram_we       = 1'b0;
      ram_widx     = sweep_idx;
      ram_wdata    = 8'h20;
      exec_byte    = four_bit_mode ? {hi_nib, lat_d} : {lat_d, 4'h0};

      case (state)
         ST_BOOT: begin
            state_d     = ST_INIT;
            sweep_idx_d = 7'd0;
            busy_cnt_d  = CNT_W'(SWEEP_LEN);
         end
         ST_INIT, ST_CLEAR: begin
            ram_we      = 1'b1;
            sweep_idx_d = sweep_idx + 7'd1;
            if (sweep_idx == 7'(SWEEP_LEN - 1)) state_d = ST_IDLE;
         end
         default: ;
      endcase

      if (stb_p2 && (state != ST_BOOT)) begin
         if (lat_rw) begin
`ifdef LCD_RESP_READ_EN
            if (four_bit_mode) phase_d = ~phase;
            if (lat_rs) begin
               if (busy) err_d = 1'b1;
               if (!four_bit_mode || phase) ac_d = ac_step(cursor_addr, entry_inc);
            end
`else
            err_d = 1'b1;
`endif
         end else if (busy) begin
            err_d = 1'b1;
         end else if (four_bit_mode && !phase) begin
            hi_nib_d = lat_d;
            phase_d  = 1'b1;
         end else begin
            phase_d     = 1'b0;
            cmd_valid_d = 1'b1;
            cmd_byte_d  = exec_byte;
            cmd_rs_d    = lat_rs;
            busy_cnt_d  = CNT_W'(BUSY_CYCLES);
            if (lat_rs) begin
               ram_we    = 1'b1;
               ram_widx  = ac_to_idx(cursor_addr);
               ram_wdata = exec_byte;
               ac_d      = ac_step(cursor_addr, entry_inc);
            end else if (exec_byte == 8'h01) begin
               state_d     = ST_CLEAR;
               sweep_idx_d = 7'd0;
               ac_d        = 7'h00;
               entry_inc_d = 1'b1;
               busy_cnt_d  = CNT_W'(CLEAR_LOAD);
            end else if (exec_byte[7:1] == 7'b0000001) begin
               ac_d       = 7'h00;
               busy_cnt_d = CNT_W'(CLEAR_CYCLES);
            end else if (exec_byte[7:2] == 6'b000001) begin
               entry_inc_d = exec_byte[1];
            end else if (exec_byte[7:3] == 5'b00001) begin
               display_on_d = exec_byte[2];
            end else if (exec_byte[7:4] == 4'b0001) begin
               if (!exec_byte[2]) ac_d = ac_step(cursor_addr, entry_inc);
            end else if (exec_byte[7:5] == 3'b001) begin
               four_bit_d = ~exec_byte[4];
            end else if (exec_byte[7:6] == 2'b01) begin
               ac_d = cursor_addr;
            end else if (addr_ok(exec_byte[6:0])) begin
               ac_d = exec_byte[6:0];
            end else begin
               err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_BOOT;
         sweep_idx     <= 7'd0;
         busy_cnt      <= '0;
         phase         <= 1'b0;
         cursor_addr   <= 7'h00;
         entry_inc     <= 1'b1;
         display_on    <= 1'b0;
         four_bit_mode <= 1'b0;
         cmd_valid     <= 1'b0;
         cmd_byte      <= 8'h00;
         cmd_rs        <= 1'b0;
         protocol_err  <= 1'b0;
         disp_char     <= 8'h00;
      end else begin
         state         <= state_d;
         sweep_idx     <= sweep_idx_d;
         busy_cnt      <= busy_cnt_d;
         phase         <= phase_d;
         cursor_addr   <= ac_d;
         entry_inc     <= entry_inc_d;
         display_on    <= display_on_d;
         four_bit_mode <= four_bit_d;
         cmd_valid     <= cmd_valid_d;
         cmd_byte      <= cmd_byte_d;
         cmd_rs        <= cmd_rs_d;
         protocol_err  <= err_d;
         disp_char     <= addr_ok(disp_addr) ? ram[ac_to_idx(disp_addr)] : 8'h00;
      end
   end

`ifdef LCD_RESP_READ_EN
   logic [7:0] ac_char;
   logic [3:0] rd_nib;
   logic       rd_oe;

   assign ac_char = ram[ac_to_idx(cursor_addr)];

   // Drive follows synchronized E/RW so the pins release within 3 clk of E falling
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_oe  <= 1'b0;
         rd_nib <= 4'h0;
      end else begin
         rd_oe <= e_p1 & rw_p1;
         if (e_p1 && rw_p1) begin
            if (rs_p1) rd_nib <= phase ? ac_char[3:0] : ac_char[7:4];
            else       rd_nib <= phase ? cursor_addr[3:0] : {busy, cursor_addr[6:4]};
         end else begin
            rd_nib <= 4'h0;
         end
      end
   end

   assign bus.sf_d_out = rd_nib;
   assign bus.sf_d_oe  = rd_oe;
`else
   assign bus.sf_d_out = 4'h0;
   assign bus.sf_d_oe  = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: directed, table-driven bench for lcd_responder.
// Busy lengths are shortened (20 / 50 cycles) so clear stretches to the 80-cycle sweep.
module tb_lcd_responder;
   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] disp_addr;
   logic [7:0] disp_char;
   logic       busy, four_bit_mode, display_on, entry_inc;
   logic [6:0] cursor_addr;
   logic       cmd_valid, cmd_rs, protocol_err;
   logic [7:0] cmd_byte;

   lcd_responder_if bus ();

   lcd_responder #(.BUSY_CYCLES(20), .CLEAR_CYCLES(50)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .disp_addr(disp_addr), .disp_char(disp_char), .busy(busy),
      .four_bit_mode(four_bit_mode), .display_on(display_on), .entry_inc(entry_inc),
      .cursor_addr(cursor_addr), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
      .cmd_rs(cmd_rs), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0, n_bad = 0;
   int   run_len = 0, last_len = 0, n_cv = 0, n_pe = 0;
   logic oe_seen = 1'b0;

   always @(negedge clk) begin
      if (busy) run_len <= run_len + 1;
      else begin
         if (run_len != 0) last_len <= run_len;
         run_len <= 0;
      end
      if (cmd_valid)    n_cv <= n_cv + 1;
      if (protocol_err) n_pe <= n_pe + 1;
      if (bus.sf_d_oe)  oe_seen <= 1'b1;
   end

   typedef struct {
      logic       rs;
      logic [7:0] b;
      logic [6:0] ac;
      logic       inc;
      int         err;
      int         blen;
   } vec_t;
   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic strobe(input logic [3:0] d, input logic rs, input logic rw,
                         output logic [3:0] q, output logic oe);
      @(negedge clk);
      bus.SF_D = d; bus.LCD_RS = rs; bus.LCD_RW = rw; bus.LCD_E = 1'b1;
      repeat (6) @(negedge clk);
      q  = bus.sf_d_out;
      oe = bus.sf_d_oe;
      bus.LCD_E = 1'b0;
      repeat (6) @(negedge clk);
      bus.LCD_RW = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic rs);
      logic [3:0] q;
      logic       oe;
      strobe(b[7:4], rs, 1'b0, q, oe);
      strobe(b[3:0], rs, 1'b0, q, oe);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (busy && t < 1000);
      if (busy) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_idle: busy stuck at 1, required 0");
      end
      @(negedge clk);
   endtask

   task automatic peek(input logic [6:0] a, input logic [7:0] exp);
      disp_addr = a;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("ddram[%0h]", a), disp_char, exp);
   endtask

   initial begin
      int         c0, e0;
      logic [3:0] q;
      logic       oe;
      logic [5:0] cv, bz;

      bus.SF_D = 4'h0; bus.LCD_E = 1'b0; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0;
      disp_addr = 7'h00;
      reset = 1'b0;

      vecs[0]  = '{1'b0, 8'hA7, 7'h27, 1'b1, 0, 20};
      vecs[1]  = '{1'b1, 8'h41, 7'h40, 1'b1, 0, 20};
      vecs[2]  = '{1'b1, 8'h42, 7'h41, 1'b1, 0, 20};
      vecs[3]  = '{1'b0, 8'h04, 7'h41, 1'b0, 0, 20};
      vecs[4]  = '{1'b0, 8'h80, 7'h00, 1'b0, 0, 20};
      vecs[5]  = '{1'b1, 8'h5A, 7'h67, 1'b0, 0, 20};
      vecs[6]  = '{1'b0, 8'hB0, 7'h67, 1'b0, 1, 20};
      vecs[7]  = '{1'b0, 8'h06, 7'h67, 1'b1, 0, 20};
      vecs[8]  = '{1'b0, 8'h02, 7'h00, 1'b1, 0, 50};
      vecs[9]  = '{1'b0, 8'h10, 7'h01, 1'b1, 0, 20};
      vecs[10] = '{1'b0, 8'hE7, 7'h67, 1'b1, 0, 20};
      vecs[11] = '{1'b1, 8'h58, 7'h00, 1'b1, 0, 20};

      repeat (3) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst entry_inc", entry_inc, 1);
      check("rst four_bit", four_bit_mode, 0);
      check("rst display_on", display_on, 0);
      check("rst cursor", cursor_addr, 0);
      check("rst cmd_valid", cmd_valid, 0);
      check("rst cmd_byte", cmd_byte, 0);
      check("rst disp_char", disp_char, 0);
      check("rst sf_d_oe", bus.sf_d_oe, 0);

      reset = 1'b1;
      wait_idle();
      check("boot busy len", last_len, 80);
      peek(7'h00, 8'h20);
      peek(7'h67, 8'h20);

      // Power-on nibbles in 8-bit mode, then 4-bit configuration bytes
      strobe(4'h3, 1'b0, 1'b0, q, oe); wait_idle();
      strobe(4'h3, 1'b0, 1'b0, q, oe); wait_idle();
      strobe(4'h3, 1'b0, 1'b0, q, oe); wait_idle();
      check("8-bit after 0x30", four_bit_mode, 0);
      strobe(4'h2, 1'b0, 1'b0, q, oe); wait_idle();
      check("4-bit after 0x20", four_bit_mode, 1);
      send_byte(8'h28, 1'b0); wait_idle();
      send_byte(8'h0C, 1'b0); wait_idle();
      send_byte(8'h06, 1'b0); wait_idle();
      send_byte(8'h01, 1'b0); wait_idle();
      check("init four_bit", four_bit_mode, 1);
      check("init display_on", display_on, 1);
      check("init entry_inc", entry_inc, 1);
      check("init cursor", cursor_addr, 0);
      check("init cmd count", n_cv, 8);
      check("init err count", n_pe, 0);
      check("clear busy len", last_len, 80);

      for (int i = 0; i < 12; i++) begin
         c0 = n_cv;
         e0 = n_pe;
         send_byte(vecs[i].b, vecs[i].rs);
         wait_idle();
         check($sformatf("v%0d cursor", i), cursor_addr, vecs[i].ac);
         check($sformatf("v%0d entry_inc", i), entry_inc, vecs[i].inc);
         check($sformatf("v%0d err pulses", i), n_pe - e0, vecs[i].err);
         check($sformatf("v%0d cmd pulses", i), n_cv - c0, 1);
         check($sformatf("v%0d cmd_byte", i), cmd_byte, vecs[i].b);
         check($sformatf("v%0d cmd_rs", i), cmd_rs, vecs[i].rs);
         check($sformatf("v%0d busy len", i), last_len, vecs[i].blen);
      end
      peek(7'h27, 8'h41);
      peek(7'h40, 8'h42);
      peek(7'h00, 8'h5A);
      peek(7'h67, 8'h58);
      peek(7'h01, 8'h20);

      // Strobe during busy is dropped; the following pair still assembles
      c0 = n_cv;
      e0 = n_pe;
      send_byte(8'h40, 1'b0);
      strobe(4'hF, 1'b0, 1'b0, q, oe);
      wait_idle();
      send_byte(8'hC5, 1'b0);
      wait_idle();
      check("busy strobe err", n_pe - e0, 1);
      check("busy strobe cmds", n_cv - c0, 2);
      check("busy strobe cursor", cursor_addr, 7'h45);

      // cmd_valid/busy rise exactly 4 clk after the pin-level E fall
      strobe(4'h0, 1'b0, 1'b0, q, oe);
      @(negedge clk);
      bus.SF_D = 4'hC; bus.LCD_RS = 1'b0; bus.LCD_E = 1'b1;
      repeat (6) @(negedge clk);
      bus.LCD_E = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         cv[k] = cmd_valid;
         bz[k] = busy;
      end
      wait_idle();
      check("exec latency cmd_valid", cv, 6'b001000);
      check("exec latency busy", bz, 6'b111000);
      check("exec latency byte", cmd_byte, 8'h0C);

`ifdef LCD_RESP_READ_EN
      send_byte(8'h01, 1'b0);
      strobe(4'h0, 1'b0, 1'b1, q, oe);
      check("rd bf nibble", q, 4'h8);
      check("rd oe", oe, 1);
      strobe(4'h0, 1'b0, 1'b1, q, oe);
      check("rd ac lo busy", q, 4'h0);
      wait_idle();
      strobe(4'h0, 1'b0, 1'b1, q, oe);
      check("rd idle hi", q, 4'h0);
      strobe(4'h0, 1'b0, 1'b1, q, oe);
      check("rd idle lo", q, 4'h0);
      strobe(4'h0, 1'b1, 1'b1, q, oe);
      check("rd data hi", q, 4'h2);
      strobe(4'h0, 1'b1, 1'b1, q, oe);
      check("rd data lo", q, 4'h0);
      wait_idle();
      check("rd data step", cursor_addr, 7'h01);
`else
      c0 = n_cv;
      e0 = n_pe;
      strobe(4'h0, 1'b0, 1'b1, q, oe);
      wait_idle();
      check("rw strobe err", n_pe - e0, 1);
      check("rw strobe cmds", n_cv - c0, 0);
      check("rw strobe nibble", q, 4'h0);
      check("rw oe never", oe_seen, 0);
      send_byte(8'h80, 1'b0);
      wait_idle();
      check("rw phase kept", cursor_addr, 7'h00);
`endif

      // Reset in the middle of a clear, then the boot sweep reruns
      send_byte(8'h01, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst busy", busy, 0);
      check("midrst four_bit", four_bit_mode, 0);
      check("midrst display_on", display_on, 0);
      check("midrst entry_inc", entry_inc, 1);
      reset = 1'b1;
      wait_idle();
      check("reboot busy len", last_len, 80);
      peek(7'h27, 8'h20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lcd_responder.md
# lcd_responder

Synthesizable HD44780-style character-LCD responder: the device end of the 4-bit LCD bus that our `lcd_ctrl` drives (`SF_D[11:8]`, `LCD_E`, `LCD_RS`, `LCD_RW`). It decodes nibble strobes into instructions and data, and maintains an 80-byte DDRAM, address counter, busy timer and display flags. With the read feature compiled in, it also answers read cycles. It is used as a bench/loopback target and as a display mirror feeding a monitor port.

## Interface
- `BUSY_CYCLES`, 2000: busy duration after an ordinary byte (40 µs at 50 MHz).
- `CLEAR_CYCLES`, 82000: busy duration after clear or home.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `SF_D`  in  4 [11:8]  data nibble from the controller.
- `LCD_E`, `LCD_RS`, `LCD_RW`  in  1 each  bus strobe, register select, read/write.
- `sf_d_out`  out  4  read-data nibble.
- `sf_d_oe`  out  1  read-drive enable.
- `disp_addr`  in  7  monitor read address.
- `disp_char`  out  8  `DDRAM[disp_addr]`, registered.
- `busy`  out  1  busy flag.
- `four_bit_mode`  out  1  interface width state.
- `display_on`  out  1  display-on flag.
- `entry_inc`  out  1  address-counter direction.
- `cursor_addr`  out  7  address counter (AC).
- `cmd_valid`  out  1  one-cycle pulse per executed byte.
- `cmd_byte`  out  8  the executed byte.
- `cmd_rs`  out  1  RS value of the executed byte.
- `protocol_err`  out  1  one-cycle error pulse.

## Operation
- Pins pass through a 2-flop synchronizer. An E rise/fall is detected on the synchronized `LCD_E`. D/RS/RW are latched on the last synchronized sample while E is high.
- Reset values:
  - All outputs 0.
  - `entry_inc`=1.
  - `four_bit_mode`=0.
- Reset sweep: after `reset` deasserts, INIT fills all 80 DDRAM bytes with 0x20, one per cycle, with `busy`=1. The sweep takes 80 cycles, then the block enters IDLE.
- Nibble phase:
  - When `four_bit_mode`=0, each write strobe is a complete byte {nibble, 4'h0}.
  - When `four_bit_mode`=1, the first strobe gives the high nibble and the second gives the low nibble; the byte executes on the second.
  - Phase resets to high on any function set.
- Instruction decode (RS=0), first matching rule:
  - 0x01 clear: DDRAM←0x20 by sweep, AC←0, `entry_inc`←1, busy `CLEAR_CYCLES`.
  - 0x02/0x03 home: AC←0, busy `CLEAR_CYCLES`.
  - 000001xx entry mode: `entry_inc`←bit1.
  - 00001xxx display control: `display_on`←bit2.
  - 0001xxxx shift: bit2=0 moves AC by one step (bit2=1 is accepted and ignored).
  - 001xxxxx function set: `four_bit_mode`←~bit4.
  - 01xxxxxx CGRAM address: accepted, no effect.
  - 1aaaaaaa DDRAM address: AC←a, provided a∈0x00–0x27 or 0x40–0x67. Otherwise AC is unchanged and `protocol_err` pulses.
- Data write (RS=1): DDRAM[AC]←byte, then AC steps.
- AC step wraps:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
- Every executed byte pulses `cmd_valid` and loads `busy` with `BUSY_CYCLES` unless another duration is specified above.
- A write strobe while `busy`=1 is discarded: no phase advance, `protocol_err` pulses.

## Timing
- Execution, the `cmd_valid` pulse and `busy` assertion occur on the same cycle, 4 clk after the pin-level E fall.
- `disp_char` latency is 1 clk after `disp_addr`. During a clear sweep it returns partially cleared contents.
- `busy` deasserts exactly N cycles after assertion (N = `BUSY_CYCLES` or `CLEAR_CYCLES`). For a clear, busy is the larger of N and the sweep length.
- Reset asserted mid-operation immediately returns the block to reset values. The sweep restarts on release.
- The controller must hold E high ≥4 clk and low ≥4 clk; narrower pulses are undefined.

## Configuration
- `LCD_RESP_READ_EN` defined:
  - While synchronized E=1 and RW=1, `sf_d_oe`=1, starting 3 clk after the pin E rise and ending ≤3 clk after the fall.
  - RS=0 reads return {BF, AC[6:4]} then AC[3:0]. These are allowed while busy and do not step AC.
  - RS=1 reads return DDRAM[AC] high then low nibble, and AC steps after the low nibble. If busy, `protocol_err` pulses.
  - Read strobes advance the nibble phase.
- Not defined:
  - `sf_d_out`=0 and `sf_d_oe`=0 constantly.
  - Any RW=1 strobe is discarded and `protocol_err` pulses.

## Test plan
- Release reset, then poll `busy` → `busy`=1 for exactly 80 cycles. After that, `disp_char`=0x20 for `disp_addr` 0x00 and 0x67.
- Send init nibbles 3,3,3,2, then bytes 0x28, 0x0C, 0x06, 0x01 with waits → `four_bit_mode`=1, `display_on`=1, `entry_inc`=1, AC=0. `cmd_valid` pulses 8 times total (4 init + 4 bytes).
- Send 0xA7 (AC←0x27) and write 'A','B' → DDRAM[0x27]=0x41, DDRAM[0x40]=0x42, AC=0x41.
- Send 0x04 (decrement), set AC 0x00, write 'Z' → DDRAM[0x00]=0x5A, AC=0x67.
- Send 0xB0 (address 0x30) → AC unchanged and one `protocol_err` pulse. A strobe during busy → `protocol_err` pulse, and the next two nibbles still assemble correctly.
- With `LCD_RESP_READ_EN`, read RS=0 right after 0x01 → first nibble 0x8 (BF=1). Read again after busy clears → 0x0, 0x0.
